weighted_sum_diff_seq: RTL and testbench

//  Sequential, parametrised successor of the fixed 6X-11Y calculator.

---
 rtl/weighted_sum_diff_seq.sv | 103 ++++++++++
 tb/tb_weighted_sum_diff_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/weighted_sum_diff_seq.sv
// Sequential CA*X -/+ CB*Y calculator: one coefficient bit per clock via shift-add,
// start/done handshake, signed result held until the next completion or reset.
module weighted_sum_diff_seq #(
  parameter int WIDTH  = 4,
  parameter int CWIDTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_mode,
  input  logic [WIDTH-1:0]          i_x,
  input  logic [WIDTH-1:0]          i_y,
  input  logic [CWIDTH-1:0]         i_ca,
  input  logic [CWIDTH-1:0]         i_cb,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [WIDTH+CWIDTH+2-1:0] o_result
);

  localparam int RW   = WIDTH + CWIDTH + 2;
  localparam int CNTW = (CWIDTH > 1) ? $clog2(CWIDTH) : 1;
  localparam logic [CNTW-1:0] LASTBIT = CNTW'(CWIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [RW-1:0]     acc;
  logic [RW-1:0]     xs;
  logic [RW-1:0]     ys;
  logic [CWIDTH-1:0] cash;
  logic [CWIDTH-1:0] cbsh;
  logic              moder;
  logic [CNTW-1:0]   cnt;

  logic [RW-1:0]     terma;
  logic [RW-1:0]     termb;
  logic [RW-1:0]     accnext;

  // Operands shift left and coefficients shift right, so bit 0 always selects the current term.
  always_comb begin
    terma   = cash[0] ? xs : '0;
    termb   = cbsh[0] ? ys : '0;
    accnext = moder ? (acc + terma + termb) : (acc + terma - termb);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
      acc      <= '0;
      cnt      <= '0;
      xs       <= '0;
      ys       <= '0;
      cash     <= '0;
      cbsh     <= '0;
      moder    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            state  <= RUN;
            o_busy <= 1'b1;
            xs     <= RW'(i_x);
            ys     <= RW'(i_y);
            cash   <= i_ca;
            cbsh   <= i_cb;
            moder  <= i_mode;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc  <= accnext;
          xs   <= xs << 1;
          ys   <= ys << 1;
          cash <= cash >> 1;
          cbsh <= cbsh >> 1;
          if (cnt == LASTBIT) begin
            state    <= DONE;
            o_result <= accnext;
            o_done   <= 1'b1;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          o_done <= 1'b0;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          o_done <= 1'b0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weighted_sum_diff_seq.sv
// Scoreboard bench for weighted_sum_diff_seq: default-size and 8x6 instances,
// expected results and completion cycles queued at start, checked on o_done.
module tb_weighted_sum_diff_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start4 = 1'b0, mode4 = 1'b0;
  logic [3:0] x4 = '0, y4 = '0, ca4 = '0, cb4 = '0;
  logic       busy4, done4;
  logic [9:0] result4;

  logic       start8 = 1'b0, mode8 = 1'b0;
  logic [7:0] x8 = '0, y8 = '0;
  logic [5:0] ca8 = '0, cb8 = '0;
  logic       busy8, done8;
  logic [15:0] result8;

  weighted_sum_diff_seq #(.WIDTH(4), .CWIDTH(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .i_mode(mode4),
    .i_x(x4), .i_y(y4), .i_ca(ca4), .i_cb(cb4),
    .o_busy(busy4), .o_done(done4), .o_result(result4)
  );

  weighted_sum_diff_seq #(.WIDTH(8), .CWIDTH(6)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_mode(mode8),
    .i_x(x8), .i_y(y8), .i_ca(ca8), .i_cb(cb8),
    .o_busy(busy8), .o_done(done8), .o_result(result8)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int expQ4[$], cycQ4[$], expQ8[$], cycQ8[$];
  int dones4 = 0, dones8 = 0, accepted4 = 0, accepted8 = 0;
  int firstRes;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every o_done pops one expected result and its expected completion cycle.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (done4 === 1'b1) begin
      dones4++;
      if (expQ4.size() == 0) checkOutput("unexpected_done4", 1, 0);
      else begin
        checkOutput("result4", $signed(result4), expQ4.pop_front());
        checkOutput("latency4", cyc, cycQ4.pop_front());
      end
    end
    if (done8 === 1'b1) begin
      dones8++;
      if (expQ8.size() == 0) checkOutput("unexpected_done8", 1, 0);
      else begin
        checkOutput("result8", $signed(result8), expQ8.pop_front());
        checkOutput("latency8", cyc, cycQ8.pop_front());
      end
    end
  end

  function automatic int model(input int x, input int y, input int ca, input int cb, input bit m);
    return m ? (ca * x + cb * y) : (ca * x - cb * y);
  endfunction

  task automatic applyStimulus(input int x, input int y, input int ca, input int cb,
                               input bit m, input bit expectAccept);
    x4 = 4'(x); y4 = 4'(y); ca4 = 4'(ca); cb4 = 4'(cb); mode4 = m;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    if (expectAccept) begin
      accepted4++;
      expQ4.push_back(model(x, y, ca, cb, m));
      cycQ4.push_back(cyc + 4);
    end
  endtask

  task automatic waitDone4();
    bit seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done4 === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) checkOutput("done4_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_busy", busy4, 0);
    checkOutput("reset_done", done4, 0);
    checkOutput("reset_result", result4, 0);
    tick();

    // Basic and boundary arithmetic
    applyStimulus(15, 15, 6, 11, 1'b0, 1'b1);
    checkOutput("busy_in_run", busy4, 1);
    waitDone4(); tick();
    applyStimulus(15, 15, 15, 15, 1'b1, 1'b1);
    waitDone4(); tick();
    applyStimulus(0, 15, 0, 15, 1'b0, 1'b1);
    waitDone4(); tick();
    checkOutput("idle_busy", busy4, 0);

    // Starts during a run are ignored
    applyStimulus(15, 15, 6, 11, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      x4 = 4'(i + 1); ca4 = 4'(i + 3); mode4 = 1'b1;
      start4 = 1'b1;
      tick();
    end
    start4 = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checkOutput("ignored_hold", $signed(result4), -75);
    checkOutput("ignored_busy", busy4, 0);

    // Reset mid-run aborts
    applyStimulus(15, 15, 15, 15, 1'b1, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(expQ4.pop_back());
    void'(cycQ4.pop_back());
    accepted4--;
    checkOutput("abort_busy", busy4, 0);
    checkOutput("abort_done", done4, 0);
    checkOutput("abort_result", result4, 0);
    for (int i = 0; i < 8; i++) tick();

    // Back-to-back, first result held through the second run
    applyStimulus(9, 4, 7, 13, 1'b0, 1'b1);
    firstRes = model(9, 4, 7, 13, 1'b0);
    waitDone4(); tick();
    applyStimulus(12, 5, 10, 3, 1'b1, 1'b1);
    tick();
    checkOutput("held_result", $signed(result4), firstRes);
    waitDone4(); tick();

    // Randomised operands
    for (int i = 0; i < 6; i++) begin
      applyStimulus($urandom_range(15), $urandom_range(15), $urandom_range(15),
                    $urandom_range(15), 1'($urandom_range(1)), 1'b1);
      waitDone4(); tick();
    end

    // Wider instance
    x8 = 8'd255; y8 = 8'd1; ca8 = 6'd63; cb8 = 6'd63; mode8 = 1'b0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    accepted8++;
    expQ8.push_back(16002);
    cycQ8.push_back(cyc + 6);
    for (int i = 0; i < 12; i++) tick();

    checkOutput("queue4_drained", expQ4.size(), 0);
    checkOutput("queue8_drained", expQ8.size(), 0);
    checkOutput("done4_count", dones4, accepted4);
    checkOutput("done8_count", dones8, accepted8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
